// File: rtl/i2c_slave_regif_if.sv
// i2c_slave_regif_if: I2C pins and register-port signals of the I2C target
interface i2c_slave_regif_if;
  logic       I2C_scl_in;
  logic       I2C_sda_in;
  logic       I2C_sda_out;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       I2C_done;
  modport slave (
    input  I2C_scl_in, I2C_sda_in, reg_rdata,
    output I2C_sda_out, reg_addr, reg_wdata, reg_wr, reg_rd, busy, I2C_done
  );
  modport master (
    output I2C_scl_in, I2C_sda_in, reg_rdata,
    input  I2C_sda_out, reg_addr, reg_wdata, reg_wr, reg_rd, busy, I2C_done
  );
endinterface

// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: oversampled I2C target exposing a pointer-addressed register port
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input logic               clk_in,
  input logic               reset,
  i2c_slave_regif_if.slave  bus
);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] IGNORE    = 4'd2;
  localparam logic [3:0] ACK_ADDR  = 4'd3;
  localparam logic [3:0] PTR       = 4'd4;
  localparam logic [3:0] ACK_PTR   = 4'd5;
  localparam logic [3:0] WDATA     = 4'd6;
  localparam logic [3:0] ACK_WDATA = 4'd7;
  localparam logic [3:0] RDATA     = 4'd8;
  localparam logic [3:0] MACK      = 4'd9;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic       r_scl_d, r_sda_d;
  logic [3:0] r_state, r_cnt;
  logic [7:0] r_shift, r_ptr, r_wdata;
  logic       r_sda, r_wr, r_rd, r_rd_q, r_busy, r_done, r_match, r_rw, r_ack;
  logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_last;
  logic [7:0] w_byte;
  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & ~r_sda_d & w_sda;
  assign w_byte  = {r_shift[6:0], w_sda};
  assign w_last  = r_cnt == 4'd7;
  // synchroniser keeps tracking the pins through reset so no false edge follows it
  always_ff @(posedge clk_in) begin
    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.I2C_scl_in};
    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.I2C_sda_in};
    r_scl_d    <= w_scl;
    r_sda_d    <= w_sda;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_ptr   <= '0;
      r_wdata <= '0;
      r_sda   <= 1'b1;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_rd_q  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_rw    <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      r_rd_q <= r_rd;
      if (r_rd_q) r_shift <= bus.reg_rdata;
      if (r_wr) r_ptr <= r_ptr + 8'd1;
      if (w_start) begin
        r_state <= ADDR;
        r_cnt   <= '0;
        r_sda   <= 1'b1;
        r_busy  <= 1'b1;
        r_match <= 1'b0;
        r_ack   <= 1'b0;
      end else if (w_stop) begin
        r_state <= IDLE;
        r_sda   <= 1'b1;
        r_busy  <= 1'b0;
        r_done  <= r_match;
        r_match <= 1'b0;
        r_ack   <= 1'b0;
      end else begin
        case (r_state)
          ADDR, PTR, WDATA: if (w_rise) begin
            r_shift <= w_byte;
            r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
            if (w_last && r_state == ADDR) begin
              r_state <= (w_byte[7:1] == DEV_ADDR) ? ACK_ADDR : IGNORE;
              r_match <= w_byte[7:1] == DEV_ADDR;
              r_rw    <= w_byte[0];
            end
            if (w_last && r_state == PTR) begin
              r_ptr   <= w_byte;
              r_state <= ACK_PTR;
            end
            if (w_last && r_state == WDATA) begin
              r_wr    <= 1'b1;
              r_wdata <= w_byte;
              r_state <= ACK_WDATA;
            end
          end
          // first fall pulls SDA low, second releases; a read hands over on the ACK rise
          ACK_ADDR, ACK_PTR, ACK_WDATA: if (w_fall) begin
            r_sda <= r_ack;
            r_ack <= ~r_ack;
            if (r_ack) r_state <= (r_state == ACK_ADDR) ? PTR : WDATA;
          end else if (w_rise && r_ack && r_state == ACK_ADDR && r_rw) begin
            r_rd    <= 1'b1;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
            r_state <= RDATA;
          end
          RDATA: if (w_fall) begin
            if (r_cnt == 4'd8) begin
              r_sda   <= 1'b1;
              r_ptr   <= r_ptr + 8'd1;
              r_state <= MACK;
            end else begin
              r_sda   <= r_shift[7];
              r_shift <= {r_shift[6:0], 1'b0};
              r_cnt   <= r_cnt + 4'd1;
            end
          end
          MACK: if (w_rise) begin
            r_rd    <= ~w_sda;
            r_cnt   <= '0;
            r_state <= w_sda ? IGNORE : RDATA;
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.I2C_sda_out = r_sda;
  assign bus.reg_addr    = r_ptr;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_wr      = r_wr;
  assign bus.reg_rd      = r_rd;
  assign bus.busy        = r_busy;
  assign bus.I2C_done    = r_done;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: bit-banged I2C master with scoreboarded register and bus traffic
module tb_i2c_slave_regif;
  localparam int Q = 8;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  int n_chk = 0, n_pass = 0, n_done = 0, d0;
  logic sda_low = 1'b0;
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$], exp_bus[$], obs_bus[$];
  always #5 clk = ~clk;
  i2c_slave_regif_if bus_if();
  assign bus_if.I2C_scl_in = m_scl;
  assign bus_if.I2C_sda_in = m_sda & bus_if.I2C_sda_out;
  assign bus_if.reg_rdata  = ~bus_if.reg_addr;
  i2c_slave_regif #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk_in(clk),
    .reset(rst),
    .bus(bus_if)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %0s got %h expected %h", nm, a, e);
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus_if.reg_wr) begin
      if (exp_wr.size() != 0) chk("reg_wr", {bus_if.reg_addr, bus_if.reg_wdata}, exp_wr.pop_front());
      else begin n_chk++; $display("FAIL reg_wr unexpected got %h%h expected none", bus_if.reg_addr, bus_if.reg_wdata); end
    end
    if (bus_if.reg_rd) begin
      if (exp_rd.size() != 0) chk("reg_rd", bus_if.reg_addr, exp_rd.pop_front());
      else begin n_chk++; $display("FAIL reg_rd unexpected got %h expected none", bus_if.reg_addr); end
    end
    if (bus_if.I2C_done) n_done++;
    if (!bus_if.I2C_sda_out) sda_low = 1'b1;
    while (obs_bus.size() != 0 && exp_bus.size() != 0) chk("bus", obs_bus.pop_front(), exp_bus.pop_front());
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask
  task automatic wbit(input logic b);
    m_sda = b; tick(Q); m_scl = 1'b1; tick(2*Q); m_scl = 1'b0; tick(Q);
  endtask
  task automatic rbit(output logic b);
    m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); b = bus_if.I2C_sda_in; tick(Q); m_scl = 1'b0; tick(Q);
  endtask
  task automatic wbyte(input logic [7:0] d, input logic exp_ack);
    logic a;
    exp_bus.push_back({7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    obs_bus.push_back({7'b0, a});
  endtask
  task automatic rbyte(input logic [7:0] e, input logic mack);
    logic b;
    logic [7:0] d;
    d = '0;
    exp_bus.push_back(e);
    for (int i = 0; i < 8; i++) begin rbit(b); d = {d[6:0], b}; end
    obs_bus.push_back(d);
    wbit(mack);
  endtask
  initial begin
    tick(4); rst = 1'b0; tick(2);
    chk("rst_sda", bus_if.I2C_sda_out, 1);
    chk("rst_addr", bus_if.reg_addr, 0);
    chk("rst_wdata", bus_if.reg_wdata, 0);
    chk("rst_strobes", {bus_if.reg_wr, bus_if.reg_rd, bus_if.busy, bus_if.I2C_done}, 0);
    d0 = n_done;
    exp_wr.push_back(16'h105A); exp_wr.push_back(16'h11C3);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'h10, 0); wbyte(8'h5A, 0); wbyte(8'hC3, 0); i2c_stop;
    chk("t1_done", n_done - d0, 1);
    chk("t1_busy", bus_if.busy, 0);
    chk("t1_ptr", bus_if.reg_addr, 8'h12);
    d0 = n_done;
    exp_rd.push_back(8'h20); exp_rd.push_back(8'h21);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'h20, 0);
    i2c_start; wbyte(8'hA1, 0); rbyte(8'hDF, 0); rbyte(8'hDE, 1);
    chk("t2_nack_sda", bus_if.I2C_sda_out, 1);
    i2c_stop;
    chk("t2_ptr", bus_if.reg_addr, 8'h22);
    chk("t2_done", n_done - d0, 1);
    d0 = n_done; sda_low = 1'b0;
    i2c_start;
    chk("t3_busy_hi", bus_if.busy, 1);
    wbyte(8'hA2, 1); wbyte(8'h00, 1); i2c_stop;
    chk("t3_busy_lo", bus_if.busy, 0);
    chk("t3_sda_low", sda_low, 0);
    chk("t3_done", n_done - d0, 0);
    d0 = n_done;
    exp_wr.push_back(16'hFF11); exp_wr.push_back(16'h0022);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'hFF, 0); wbyte(8'h11, 0); wbyte(8'h22, 0); i2c_stop;
    chk("t4_ptr", bus_if.reg_addr, 8'h01);
    chk("t4_done", n_done - d0, 1);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'h30, 0);
    for (int i = 0; i < 4; i++) wbit(i[0]);
    i2c_stop;
    chk("t5_busy", bus_if.busy, 0);
    chk("t5_ptr", bus_if.reg_addr, 8'h30);
    exp_wr.push_back(16'h4077);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'h40, 0); wbyte(8'h77, 0); i2c_stop;
    chk("t5_ptr2", bus_if.reg_addr, 8'h41);
    exp_rd.push_back(8'h80);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'h80, 0);
    i2c_start; wbyte(8'hA1, 0);
    chk("t6_bit7_low", bus_if.I2C_sda_out, 0);
    d0 = n_done;
    rst = 1'b1; tick(1);
    chk("t6_sda", bus_if.I2C_sda_out, 1);
    chk("t6_addr", bus_if.reg_addr, 0);
    chk("t6_busy", bus_if.busy, 0);
    rst = 1'b0; tick(2);
    i2c_stop;
    chk("t6_no_done", n_done - d0, 0);
    exp_wr.push_back(16'h0533);
    i2c_start; wbyte(8'hA0, 0); wbyte(8'h05, 0); wbyte(8'h33, 0); i2c_stop;
    chk("t6_done", n_done - d0, 1);
    tick(4);
    chk("wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("bus_left", exp_bus.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
- I2C target (responder) for the FPGA fabric, oversampling SCL/SDA on the system clock.
- Answers one 7-bit device address.
- Writes: the first data byte loads a register pointer; later bytes write through a simple register port.
- Reads: bytes are fetched from the register port with pointer auto-increment.
- Used as the on-chip peer of the team's I2C master for loopback test and for exposing FPGA config/status registers to an external host.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on I2C_scl_in/I2C_sda_in (min 2).

Ports:
- clk_in  input  1  system clock; must be >= 16x SCL frequency.
- reset  input  1  synchronous, active-high reset.
- I2C_scl_in  input  1  bus SCL level.
- I2C_sda_in  input  1  bus SDA level.
- I2C_sda_out  output  1  0 = pull SDA low, 1 = release (open-drain pad outside).
- reg_addr  output  8  register pointer; always equals internal pointer.
- reg_wdata  output  8  write byte; valid while reg_wr=1.
- reg_wr  output  1  one-cycle write strobe.
- reg_rd  output  1  one-cycle read request; user drives reg_rdata on the next cycle.
- reg_rdata  input  8  read data; captured one clk_in cycle after reg_rd.
- busy  output  1  high from detected START to detected STOP.
- I2C_done  output  1  one-cycle pulse on STOP that ends an addressed transaction.

Behaviour:
- Reset values: I2C_sda_out=1, reg_addr=0 (pointer=0), reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, I2C_done=0, state IDLE, bit counter 0.
- Reset mid-transfer releases SDA on the next cycle and discards the partial byte.
- Synchronise SCL/SDA, then register once more for edge detection.
  - scl_rise/scl_fall come from synced SCL.
- START = synced SDA falls while synced SCL high.
- STOP = synced SDA rises while synced SCL high.
- START/STOP have priority over every state:
  - START (incl. repeated): go to ADDR, clear the bit counter, release SDA, busy=1.
  - STOP: go to IDLE, release SDA, busy=0; I2C_done pulses if the address had matched.
- Data is sampled on scl_rise, MSB first. SDA changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - After the 8th rise: if byte[7:1]==DEV_ADDR, go to ACK_ADDR and latch the R/W bit; else go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
  - ACK_ADDR: on scl_fall drive SDA=0; on the next scl_fall release.
    - Write: go to PTR.
    - Read: go to RDATA.
    - For read, reg_rd pulses the cycle after the ACK bit's scl_rise; reg_rdata is latched into the shift register one cycle later.
  - PTR: shift 8 bits; after the 8th rise, pointer <= byte. Then ACK_PTR (same ACK timing), then WDATA.
  - WDATA: shift 8 bits.
    - After the 8th rise, the next cycle has reg_wr=1, reg_addr=pointer, reg_wdata=byte.
    - The cycle after that, pointer+1 (8-bit wrap 0xFF->0x00).
    - Then ACK_WDATA, then WDATA.
  - RDATA: bit 7 is driven on the scl_fall that ends the preceding ACK; the remaining bits on each following scl_fall.
    - After the 8th bit's scl_fall: release SDA, pointer+1, go to MACK.
  - MACK: sample SDA on scl_rise.
    - 0 (ACK): pulse reg_rd, latch data, go to RDATA.
    - 1 (NACK): go to IGNORE.
- Data 1-bits in RDATA are driven as release (I2C_sda_out=1); 0-bits as pull low.
- STOP or START mid-byte: partial byte dropped, no reg_wr.
- The pointer persists across transactions, so write-pointer + repeated START + read works.
- Never drive SDA while SCL is high except holding an ACK/data bit set on the prior fall.

Test Plan:
- START, 0xA0, 0x10, 0x5A, 0xC3, STOP -> ACK on all 4 bytes.
  - reg_wr pulses twice: (0x10,0x5A) then (0x11,0xC3).
  - I2C_done 1 pulse; busy low after STOP.
- START, 0xA0, 0x20, Sr, 0xA1, read 2 bytes (master ACK then NACK), STOP, with user reg_rdata=~reg_addr -> bus bytes 0xDF, 0xDE.
  - reg_rd pulses exactly twice.
  - SDA released after NACK; pointer ends at 0x22.
- START, 0xA2, 0x00, STOP -> I2C_sda_out stays 1 throughout; no reg_wr/reg_rd; I2C_done stays 0; busy high START..STOP.
- Pointer 0xFF, write 2 bytes 0x11, 0x22 -> writes at 0xFF then 0x00 (wrap).
- STOP after 4 bits of a WDATA byte -> no reg_wr, state IDLE.
  - The next write transaction completes normally.
- Assert reset during RDATA while SDA is driven low -> I2C_sda_out=1 the next cycle, reg_addr=0, busy=0; bus recovers on the next START.
